// File: rtl/hd44780_ram_scanner.sv
// LCD refresh sequencer: walks ROWS x COLS chars out of hd44780_ram and emits
// set-DDRAM-address commands plus char bytes on a valid/ready stream.
// Ports: clk, rst_n, start, busy, frame_done, raddr (to RAM), rdata (from RAM),
//        out_valid, out_ready, out_rs (0 cmd / 1 data), out_byte.
module hd44780_ram_scanner #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 2,
  parameter int COLS       = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_rs,
  output logic [7:0]            out_byte
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_FETCH,
    S_LATCH,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [1:0] ROW_LAST = 2'(ROWS - 1);
  localparam logic [5:0] COL_LAST = 6'(COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t state, state_n;
  logic [1:0] row, row_n;
  logic [5:0] col, col_n;
  logic [ADDR_WIDTH-1:0] raddr_n;
  logic [7:0] byte_n;
  logic rs_n;
  logic xfer;

  // Row start offsets in DDRAM for 1..4 line panels.
  function automatic logic [7:0] row_cmd(input logic [1:0] r);
    logic [7:0] c;
    case (r)
      2'd0:    c = 8'h80;
      2'd1:    c = 8'hC0;
      2'd2:    c = 8'h94;
      default: c = 8'hD4;
    endcase
    return c;
  endfunction

  // Linear RAM address; wraps silently at 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(
    input logic [1:0] r,
    input logic [5:0] c
  );
    logic [31:0] lin;
    lin = 32'(BASE_ADDR) + 32'(r) * 32'(COLS) + 32'(c);
    return lin[ADDR_WIDTH-1:0];
  endfunction

  assign xfer       = out_valid && out_ready;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  assign out_valid  = (state == S_CMD) || (state == S_DATA);

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    raddr_n = raddr;
    byte_n  = out_byte;
    rs_n    = out_rs;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CMD;
          row_n   = 2'd0;
          col_n   = 6'd0;
          byte_n  = row_cmd(2'd0);
          rs_n    = 1'b0;
        end
      end
      S_CMD: begin
        if (xfer) begin
          state_n = S_FETCH;
          raddr_n = addr_of(row, col);
        end
      end
      S_FETCH: state_n = S_LATCH;
      S_LATCH: begin
        state_n = S_DATA;
        byte_n  = rdata[7:0];
        rs_n    = 1'b1;
      end
      S_DATA: begin
        if (xfer) begin
          if (col != COL_LAST) begin
            col_n   = col + 6'd1;
            state_n = S_FETCH;
            raddr_n = addr_of(row, col + 6'd1);
          end else begin
            col_n = 6'd0;
            if (row != ROW_LAST) begin
              row_n   = row + 2'd1;
              state_n = S_CMD;
              byte_n  = row_cmd(row + 2'd1);
              rs_n    = 1'b0;
            end else begin
              state_n = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      row      <= 2'd0;
      col      <= 6'd0;
      raddr    <= BASE;
      out_byte <= 8'h00;
      out_rs   <= 1'b0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      col      <= col_n;
      raddr    <= raddr_n;
      out_byte <= byte_n;
      out_rs   <= rs_n;
    end
  end

  if (DATA_WIDTH > 8) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^rdata[DATA_WIDTH-1:8];
  end

endmodule

// File: tb/tb_hd44780_ram_scanner.sv
// Bench for hd44780_ram_scanner: a 2x16 instance and a 4x20 instance at 0x100,
// each fed by a registered-read RAM model; streams checked against a frame model.
module tb_hd44780_ram_scanner;

  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic start_a = 1'b0, rdy_a = 1'b1;
  logic busy_a, fd_a, ov_a, rs_a;
  logic [7:0] byte_a, rdata_a;
  logic [AW-1:0] raddr_a;

  logic start_b = 1'b0, rdy_b = 1'b1;
  logic busy_b, fd_b, ov_b, rs_b;
  logic [7:0] byte_b, rdata_b;
  logic [AW-1:0] raddr_b;

  logic [7:0] mem_a[512];
  logic [7:0] mem_b[512];

  hd44780_ram_scanner #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(8), .ROWS(2), .COLS(16), .BASE_ADDR(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a),
    .frame_done(fd_a), .raddr(raddr_a), .rdata(rdata_a),
    .out_valid(ov_a), .out_ready(rdy_a), .out_rs(rs_a), .out_byte(byte_a)
  );

  hd44780_ram_scanner #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(8), .ROWS(4), .COLS(20), .BASE_ADDR('h100)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b),
    .frame_done(fd_b), .raddr(raddr_b), .rdata(rdata_b),
    .out_valid(ov_b), .out_ready(rdy_b), .out_rs(rs_b), .out_byte(byte_b)
  );

  always @(posedge clk) rdata_a <= mem_a[raddr_a];
  always @(posedge clk) rdata_b <= mem_b[raddr_b];

  int total = 0;
  int bad = 0;
  logic [8:0] got_a[$];
  logic [8:0] got_b[$];
  logic [AW-1:0] addr_b[$];
  int fd_cnt_a = 0;
  int fd_cnt_b = 0;
  logic pv_b = 1'b0;

  // Observe stable values mid-cycle; a transfer seen here lands on the next edge.
  always @(negedge clk) begin
    if (ov_a && rdy_a) got_a.push_back({rs_a, byte_a});
    if (fd_a) fd_cnt_a++;
    if (ov_b && rdy_b) got_b.push_back({rs_b, byte_b});
    if (fd_b) fd_cnt_b++;
    if (busy_b && !ov_b && !fd_b && pv_b) addr_b.push_back(raddr_b);
    pv_b = ov_b;
  end

  task automatic model_frame(input int rows, input int cols, input int base,
                             input logic [7:0] m[512], output logic [8:0] q[$]);
    int rb[4] = '{'h00, 'h40, 'h14, 'h54};
    q = {};
    for (int r = 0; r < rows; r++) begin
      q.push_back({1'b0, 8'('h80 + rb[r])});
      for (int c = 0; c < cols; c++)
        q.push_back({1'b1, m[(base + r * cols + c) % 512]});
    end
  endtask

  function automatic int first_diff(input logic [8:0] a[$], input logic [8:0] b[$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++)
      if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!busy_a) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic fill_a(input bit ascii);
    for (int i = 0; i < 512; i++) mem_a[i] = 8'($urandom);
    if (ascii)
      for (int i = 0; i < 32; i++) mem_a[i] = 8'('h41 + i);
  endtask

  task automatic test_reset();
    #13;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy_a !== 1'b0 || fd_a !== 1'b0 || ov_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: busy=%b done=%b valid=%b want 000", busy_a, fd_a, ov_a);
    end
    total++;
    if (rs_a !== 1'b0 || byte_a !== 8'h00) begin
      bad++;
      $display("FAIL reset_out: rs=%b byte=%h want 0 00", rs_a, byte_a);
    end
    total++;
    if (raddr_a !== 9'h000 || raddr_b !== 9'h100) begin
      bad++;
      $display("FAIL reset_raddr: a=%h b=%h want 000 100", raddr_a, raddr_b);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if (busy_a !== 1'b0 || ov_a !== 1'b0 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy_a=%b valid_a=%b busy_b=%b want 000",
               busy_a, ov_a, busy_b);
    end
  endtask

  task automatic test_basic();
    logic [8:0] exp_q[$];
    int fd_hits, fd_cycle, busy_bad, idx;
    fill_a(1'b1);
    got_a = {};
    rdy_a = 1'b1;
    fd_hits = 0;
    fd_cycle = -1;
    busy_bad = 0;
    pulse_a();
    for (int k = 1; k <= 110; k++) begin
      if (fd_a === 1'b1) begin
        fd_hits++;
        fd_cycle = k;
      end
      if (busy_a !== (k <= 99)) busy_bad++;
      tick();
    end
    total++;
    if (fd_hits != 1 || fd_cycle != 99) begin
      bad++;
      $display("FAIL basic_done: hits=%0d cycle=%0d want 1 99", fd_hits, fd_cycle);
    end
    total++;
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL basic_busy: %0d wrong cycles want 0", busy_bad);
    end
    model_frame(2, 16, 0, mem_a, exp_q);
    idx = first_diff(got_a, exp_q);
    total++;
    if (idx != -1) begin
      bad++;
      $display("FAIL basic_stream: idx=%0d got=%h want=%h n=%0d want n=%0d",
               idx, (idx < got_a.size()) ? got_a[idx] : 9'h1FF,
               (idx < exp_q.size()) ? exp_q[idx] : 9'h1FF, got_a.size(), exp_q.size());
    end
    total++;
    if (got_a.size() < 18 || got_a[0] !== 9'h080 || got_a[1] !== 9'h141 ||
        got_a[17] !== 9'h0C0) begin
      bad++;
      $display("FAIL basic_heads: size=%0d want 34 with 080 141 ... 0C0", got_a.size());
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp_q[$];
    bit found, ok;
    int hold_bad, idx;
    fill_a(1'b1);
    got_a = {};
    fd_cnt_a = 0;
    rdy_a = 1'b1;
    found = 1'b0;
    hold_bad = 0;
    pulse_a();
    for (int i = 0; i < 100; i++) begin
      if (ov_a === 1'b1 && rs_a === 1'b1 && byte_a === 8'h43) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    rdy_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!(ov_a === 1'b1 && rs_a === 1'b1 && byte_a === 8'h43)) hold_bad++;
    end
    rdy_a = 1'b1;
    wait_idle_a(200, ok);
    total++;
    if (!found || !ok) begin
      bad++;
      $display("FAIL bp_progress: found43=%b finished=%b want 1 1", found, ok);
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL bp_hold: %0d unstable cycles want 0", hold_bad);
    end
    model_frame(2, 16, 0, mem_a, exp_q);
    idx = first_diff(got_a, exp_q);
    total++;
    if (idx != -1) begin
      bad++;
      $display("FAIL bp_stream: idx=%0d n=%0d want n=%0d", idx, got_a.size(), exp_q.size());
    end
    total++;
    if (fd_cnt_a != 1) begin
      bad++;
      $display("FAIL bp_done: count=%0d want 1", fd_cnt_a);
    end
  endtask

  task automatic test_start_ignored();
    logic [8:0] exp_q[$];
    bit pc, pd, pdone;
    int idx;
    fill_a(1'b0);
    got_a = {};
    fd_cnt_a = 0;
    rdy_a = 1'b1;
    pc = 1'b0;
    pd = 1'b0;
    pdone = 1'b0;
    pulse_a();
    for (int k = 0; k < 200; k++) begin
      start_a = 1'b0;
      if (!pc && ov_a === 1'b1 && rs_a === 1'b0) begin
        start_a = 1'b1;
        pc = 1'b1;
      end else if (!pd && ov_a === 1'b1 && rs_a === 1'b1) begin
        start_a = 1'b1;
        pd = 1'b1;
      end else if (!pdone && fd_a === 1'b1) begin
        start_a = 1'b1;
        pdone = 1'b1;
      end
      tick();
    end
    start_a = 1'b0;
    total++;
    if (!(pc && pd && pdone)) begin
      bad++;
      $display("FAIL ign_reach: cmd=%b data=%b done=%b want 111", pc, pd, pdone);
    end
    total++;
    if (fd_cnt_a != 1 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL ign_frames: done_count=%0d busy=%b want 1 0", fd_cnt_a, busy_a);
    end
    model_frame(2, 16, 0, mem_a, exp_q);
    idx = first_diff(got_a, exp_q);
    total++;
    if (idx != -1) begin
      bad++;
      $display("FAIL ign_stream: idx=%0d n=%0d want n=%0d", idx, got_a.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] exp_q[$];
    bit ok;
    int idx;
    fill_a(1'b0);
    got_a = {};
    rdy_a = 1'b1;
    pulse_a();
    for (int i = 0; i < 60; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (ov_a !== 1'b0 || busy_a !== 1'b0 || raddr_a !== 9'h000) begin
      bad++;
      $display("FAIL midrst_now: valid=%b busy=%b raddr=%h want 0 0 000",
               ov_a, busy_a, raddr_a);
    end
    tick();
    rst_n = 1'b1;
    tick();
    got_a = {};
    fd_cnt_a = 0;
    pulse_a();
    tick();
    total++;
    if (raddr_a !== 9'h000 || ov_a !== 1'b0) begin
      bad++;
      $display("FAIL midrst_fetch: raddr=%h valid=%b want 000 0", raddr_a, ov_a);
    end
    wait_idle_a(200, ok);
    model_frame(2, 16, 0, mem_a, exp_q);
    idx = first_diff(got_a, exp_q);
    total++;
    if (!ok || idx != -1 || fd_cnt_a != 1) begin
      bad++;
      $display("FAIL midrst_stream: finished=%b idx=%0d done_count=%0d want 1 -1 1",
               ok, idx, fd_cnt_a);
    end
  endtask

  task automatic test_big_frame();
    logic [8:0] exp_q[$];
    bit ok, pv, pr, prs;
    logic [7:0] pbyte;
    int hold_bad, idx, addr_bad;
    for (int i = 0; i < 512; i++) mem_b[i] = 8'($urandom);
    got_b = {};
    addr_b = {};
    fd_cnt_b = 0;
    hold_bad = 0;
    ok = 1'b0;
    pv = 1'b0;
    pr = 1'b1;
    prs = 1'b0;
    pbyte = 8'h00;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (pv && !pr)
        if (!(ov_b === 1'b1 && byte_b === pbyte && rs_b === prs)) hold_bad++;
      if (!busy_b) begin
        ok = 1'b1;
        break;
      end
      pv = ov_b;
      pbyte = byte_b;
      prs = rs_b;
      rdy_b = ($urandom_range(0, 3) != 0);
      pr = rdy_b;
      tick();
    end
    rdy_b = 1'b1;
    total++;
    if (!ok || hold_bad != 0 || fd_cnt_b != 1) begin
      bad++;
      $display("FAIL big_flow: finished=%b hold_bad=%0d done_count=%0d want 1 0 1",
               ok, hold_bad, fd_cnt_b);
    end
    model_frame(4, 20, 'h100, mem_b, exp_q);
    idx = first_diff(got_b, exp_q);
    total++;
    if (idx != -1) begin
      bad++;
      $display("FAIL big_stream: idx=%0d n=%0d want n=%0d", idx, got_b.size(), exp_q.size());
    end
    total++;
    if (got_b.size() != 84 || got_b[0] !== 9'h080 || got_b[21] !== 9'h0C0 ||
        got_b[42] !== 9'h094 || got_b[63] !== 9'h0D4) begin
      bad++;
      $display("FAIL big_cmds: n=%0d want 84 with 080 0C0 094 D4", got_b.size());
    end
    total++;
    if (addr_b.size() != 80 || addr_b[40] !== 9'h128 || addr_b[79] !== 9'h14F) begin
      bad++;
      $display("FAIL big_addr_ends: n=%0d row2=%h last=%h want 80 128 14F",
               addr_b.size(), (addr_b.size() > 40) ? addr_b[40] : 9'h000,
               (addr_b.size() > 79) ? addr_b[79] : 9'h000);
    end
    addr_bad = 0;
    for (int i = 0; i < addr_b.size(); i++)
      if (addr_b[i] !== 9'('h100 + i)) addr_bad++;
    total++;
    if (addr_bad != 0) begin
      bad++;
      $display("FAIL big_addr_seq: %0d wrong addresses want 0", addr_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_reset_midframe();
    test_big_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
